riscv_mem_arbiter: RTL and testbench

- Arbitrates a single-port unified memory between the fetch stage (IF port) and the memory stage (DM port) of the RV32 core.
- Allows one outstanding transaction at a time, with back-to-back grants when the response arrives.
- Gives data accesses fixed priority, with an anti-starvation counter that forces an IF grant after STARVE_MAX consecutive denied fetches.
- Routes each memory response to the port that owns the transaction, and flags responses that arrive with no transaction outstanding.

---
 rtl/riscv_mem_arbiter_if.sv | 55 +++++
 rtl/riscv_mem_arbiter.sv | 120 ++++++++++++
 tb/tb_riscv_mem_arbiter.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_mem_arbiter_if.sv
// Bus bundle for the unified-memory arbiter: fetch port, data port and memory port.
// slave  : seen from the arbiter (requests in, grants/responses/memory command out).
// master : seen from the surrounding core/memory model.
interface riscv_mem_arbiter_if #(
    parameter int unsigned XLEN = 32
);
    // fetch port
    logic            if_req_i;
    logic [XLEN-1:0] if_addr_i;
    logic            if_gnt_o;
    logic            if_rvalid_o;
    logic [XLEN-1:0] if_rdata_o;

    // data port
    logic            dm_req_i;
    logic            dm_we_i;
    logic [3:0]      dm_be_i;
    logic [XLEN-1:0] dm_addr_i;
    logic [XLEN-1:0] dm_wdata_i;
    logic            dm_gnt_o;
    logic            dm_rvalid_o;
    logic [XLEN-1:0] dm_rdata_o;

    // memory port
    logic            mem_req_o;
    logic            mem_we_o;
    logic [3:0]      mem_be_o;
    logic [XLEN-1:0] mem_addr_o;
    logic [XLEN-1:0] mem_wdata_o;
    logic            mem_rvalid_i;
    logic [XLEN-1:0] mem_rdata_i;

    // unexpected-response flag
    logic            err_o;

    modport slave (
        input  if_req_i, if_addr_i,
        input  dm_req_i, dm_we_i, dm_be_i, dm_addr_i, dm_wdata_i,
        input  mem_rvalid_i, mem_rdata_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        output dm_gnt_o, dm_rvalid_o, dm_rdata_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output err_o
    );

    modport master (
        output if_req_i, if_addr_i,
        output dm_req_i, dm_we_i, dm_be_i, dm_addr_i, dm_wdata_i,
        output mem_rvalid_i, mem_rdata_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        input  dm_gnt_o, dm_rvalid_o, dm_rdata_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  err_o
    );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// Single-port unified memory arbiter between the fetch (IF) and memory (DM) stages.
// One transaction outstanding at a time; DM has fixed priority, with an
// anti-starvation counter that forces an IF grant after STARVE_MAX denied fetches.
// Responses are routed to the owning port; a response with nothing outstanding
// pulses err_o and is dropped.
module riscv_mem_arbiter #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rstn,
    riscv_mem_arbiter_if.slave  bus
);

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("riscv_mem_arbiter: STARVE_MAX must be in 1..15");
    end

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_IF = 2'd1,
        WAIT_DM = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      starve_q, starve_d;
    logic            window;
    logic            if_force;
    logic            grant_dm;
    logic            grant_if;
    logic [XLEN-1:0] rsp_data;

    assign rsp_data = bus.mem_rdata_i;

    // Grant window and priority decision; everything is held off while in reset.
    always_comb begin
        window = 1'b0;
        if (rstn) begin
            window = (state_q == IDLE) || bus.mem_rvalid_i;
        end
        if_force = (starve_q == STARVE_LIM);
        grant_dm = window && bus.dm_req_i && !(bus.if_req_i && if_force);
        grant_if = window && bus.if_req_i && !grant_dm;
    end

    // State register and starvation counter.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Next state and counter update, both only when the grant window is open.
    // An unexpected response in IDLE opens no new path: with no grant it stays IDLE.
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        if (window) begin
            if (grant_dm) begin
                state_d = WAIT_DM;
            end else if (grant_if) begin
                state_d = WAIT_IF;
            end else begin
                state_d = IDLE;
            end

            if (grant_if || !bus.if_req_i) begin
                starve_d = '0;
            end else if (grant_dm && (starve_q != STARVE_LIM)) begin
                starve_d = starve_q + 4'd1;
            end
        end
    end

    // Grants, memory command mux and response routing.
    always_comb begin
        bus.if_gnt_o    = grant_if;
        bus.dm_gnt_o    = grant_dm;
        bus.mem_req_o   = grant_if || grant_dm;
        bus.mem_we_o    = 1'b0;
        bus.mem_be_o    = '0;
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = '0;
        bus.if_rvalid_o = 1'b0;
        bus.dm_rvalid_o = 1'b0;
        bus.if_rdata_o  = '0;
        bus.dm_rdata_o  = '0;
        bus.err_o       = 1'b0;

        if (grant_dm) begin
            bus.mem_we_o    = bus.dm_we_i;
            bus.mem_be_o    = bus.dm_be_i;
            bus.mem_addr_o  = bus.dm_addr_i;
            bus.mem_wdata_o = bus.dm_wdata_i;
        end else if (grant_if) begin
            bus.mem_be_o    = '1;
            bus.mem_addr_o  = bus.if_addr_i;
        end

        // state_q may still be WAIT_* during the reset cycle, so gate on rstn
        if (rstn) begin
            bus.if_rvalid_o = (state_q == WAIT_IF) && bus.mem_rvalid_i;
            bus.dm_rvalid_o = (state_q == WAIT_DM) && bus.mem_rvalid_i;
            bus.err_o       = (state_q == IDLE)    && bus.mem_rvalid_i;
            if (bus.if_rvalid_o) begin
                bus.if_rdata_o = rsp_data;
            end
            if (bus.dm_rvalid_o) begin
                bus.dm_rdata_o = rsp_data;
            end
        end
    end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Self-checking bench for riscv_mem_arbiter: directed scenarios plus a randomized
// run against a transaction-level reference model (busy flag, owner, denied-fetch count).
module tb_riscv_mem_arbiter;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned STARVE_MAX = 4;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    riscv_mem_arbiter_if #(.XLEN(XLEN)) bus ();

    riscv_mem_arbiter #(
        .XLEN       (XLEN),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    // reference model state
    bit          m_busy;
    bit          m_dm_own;
    int unsigned m_starve;

    // model expectations for the current cycle
    logic        e_if_gnt, e_dm_gnt, e_mem_req, e_mem_we;
    logic [3:0]  e_mem_be;
    logic [31:0] e_mem_addr, e_mem_wdata;
    logic        e_if_rv, e_dm_rv, e_err;
    logic [31:0] e_if_rd, e_dm_rd;
    bit          e_window;

    function automatic void model_eval();
        e_if_gnt = 0; e_dm_gnt = 0; e_mem_req = 0; e_mem_we = 0; e_mem_be = 0;
        e_mem_addr = 0; e_mem_wdata = 0; e_if_rv = 0; e_dm_rv = 0; e_err = 0;
        e_if_rd = 0; e_dm_rd = 0; e_window = 0;
        if (rstn) begin
            e_window = !m_busy || bus.mem_rvalid_i;
            if (e_window && bus.dm_req_i && !(bus.if_req_i && m_starve == STARVE_MAX))
                e_dm_gnt = 1;
            else if (e_window && bus.if_req_i)
                e_if_gnt = 1;
            e_mem_req = e_if_gnt | e_dm_gnt;
            if (e_dm_gnt) begin
                e_mem_we = bus.dm_we_i; e_mem_be = bus.dm_be_i;
                e_mem_addr = bus.dm_addr_i; e_mem_wdata = bus.dm_wdata_i;
            end else if (e_if_gnt) begin
                e_mem_be = 4'hF; e_mem_addr = bus.if_addr_i;
            end
            e_if_rv = m_busy && !m_dm_own && bus.mem_rvalid_i;
            e_dm_rv = m_busy && m_dm_own && bus.mem_rvalid_i;
            e_err   = !m_busy && bus.mem_rvalid_i;
            if (e_if_rv) e_if_rd = bus.mem_rdata_i;
            if (e_dm_rv) e_dm_rd = bus.mem_rdata_i;
        end
    endfunction

    function automatic void model_commit();
        if (!rstn) begin
            m_busy = 0; m_dm_own = 0; m_starve = 0;
        end else if (e_window) begin
            if (e_dm_gnt) begin
                m_busy = 1; m_dm_own = 1;
                if (!bus.if_req_i) m_starve = 0;
                else if (m_starve < STARVE_MAX) m_starve = m_starve + 1;
            end else if (e_if_gnt) begin
                m_busy = 1; m_dm_own = 0; m_starve = 0;
            end else begin
                m_busy = 0; m_starve = 0;
            end
        end
    endfunction

    task automatic idle_inputs();
        rstn = 1'b1;
        bus.if_req_i = 1'b0; bus.if_addr_i = '0;
        bus.dm_req_i = 1'b0; bus.dm_we_i = 1'b0; bus.dm_be_i = '0;
        bus.dm_addr_i = '0; bus.dm_wdata_i = '0;
        bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;
    endtask

    // let combinational outputs settle, then compute expectations
    task automatic settle();
        #2;
        model_eval();
    endtask

    // advance one clock; model state follows the edge
    task automatic tick();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            idle_inputs();
            rstn = 1'b0;
            bus.if_req_i = 1'b1; bus.if_addr_i = 32'h40;
            bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b1; bus.dm_be_i = 4'hF;
            bus.dm_addr_i = 32'h80; bus.dm_wdata_i = 32'h1234;
            bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hFFFF_FFFF;
            settle();
            checks++;
            if ({bus.if_gnt_o, bus.dm_gnt_o, bus.mem_req_o, bus.mem_we_o, bus.mem_be_o,
                 bus.if_rvalid_o, bus.dm_rvalid_o, bus.err_o} !== 11'b0) begin
                failures++;
                $display("FAIL reset_ctrl got=%b exp=0", {bus.if_gnt_o, bus.dm_gnt_o, bus.mem_req_o,
                         bus.mem_we_o, bus.mem_be_o, bus.if_rvalid_o, bus.dm_rvalid_o, bus.err_o});
            end
            checks++;
            if ({bus.mem_addr_o, bus.mem_wdata_o, bus.if_rdata_o, bus.dm_rdata_o} !== 128'b0) begin
                failures++;
                $display("FAIL reset_data got=%h %h %h %h exp=0", bus.mem_addr_o, bus.mem_wdata_o,
                         bus.if_rdata_o, bus.dm_rdata_o);
            end
            tick();
        end
        idle_inputs();
        settle();
        checks++;
        if ({bus.if_gnt_o, bus.dm_gnt_o, bus.mem_req_o, bus.err_o} !== 4'b0) begin
            failures++;
            $display("FAIL reset_idle got=%b exp=0000", {bus.if_gnt_o, bus.dm_gnt_o, bus.mem_req_o, bus.err_o});
        end
        tick();
    endtask

    task automatic test_single_fetch();
        idle_inputs();
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h0000_0010;
        settle();
        checks++;
        if ({bus.if_gnt_o, bus.dm_gnt_o, bus.mem_req_o, bus.mem_we_o, bus.mem_be_o} !== 8'b1010_1111) begin
            failures++;
            $display("FAIL fetch_gnt got=%b exp=10101111",
                     {bus.if_gnt_o, bus.dm_gnt_o, bus.mem_req_o, bus.mem_we_o, bus.mem_be_o});
        end
        checks++;
        if (bus.mem_addr_o !== 32'h0000_0010) begin
            failures++;
            $display("FAIL fetch_addr got=%h exp=00000010", bus.mem_addr_o);
        end
        tick();
        idle_inputs();
        bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h0050_0093;
        settle();
        checks++;
        if ({bus.if_rvalid_o, bus.dm_rvalid_o, bus.err_o} !== 3'b100) begin
            failures++;
            $display("FAIL fetch_rvalid got=%b exp=100", {bus.if_rvalid_o, bus.dm_rvalid_o, bus.err_o});
        end
        checks++;
        if (bus.if_rdata_o !== 32'h0050_0093 || bus.dm_rdata_o !== 32'h0) begin
            failures++;
            $display("FAIL fetch_rdata got=%h/%h exp=00500093/00000000", bus.if_rdata_o, bus.dm_rdata_o);
        end
        tick();
    endtask

    task automatic test_simultaneous();
        idle_inputs();
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h20;
        bus.dm_req_i = 1'b1; bus.dm_be_i = 4'hF; bus.dm_addr_i = 32'h100;
        settle();
        checks++;
        if ({bus.if_gnt_o, bus.dm_gnt_o} !== 2'b01 || bus.mem_addr_o !== 32'h100 || bus.mem_we_o !== 1'b0) begin
            failures++;
            $display("FAIL simul_gnt got=%b addr=%h exp=01 addr=00000100", {bus.if_gnt_o, bus.dm_gnt_o}, bus.mem_addr_o);
        end
        tick();
        bus.dm_req_i = 1'b0;
        bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h1111_2222;
        settle();
        checks++;
        if ({bus.dm_rvalid_o, bus.if_rvalid_o} !== 2'b10 || bus.dm_rdata_o !== 32'h1111_2222) begin
            failures++;
            $display("FAIL simul_dm_rsp got=%b %h exp=10 11112222", {bus.dm_rvalid_o, bus.if_rvalid_o}, bus.dm_rdata_o);
        end
        checks++;
        if ({bus.if_gnt_o, bus.mem_req_o} !== 2'b11 || bus.mem_addr_o !== 32'h20) begin
            failures++;
            $display("FAIL simul_b2b got=%b addr=%h exp=11 addr=00000020", {bus.if_gnt_o, bus.mem_req_o}, bus.mem_addr_o);
        end
        tick();
        idle_inputs();
        bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h3333_4444;
        settle();
        checks++;
        if (bus.if_rvalid_o !== 1'b1 || bus.if_rdata_o !== 32'h3333_4444) begin
            failures++;
            $display("FAIL simul_if_rsp got=%b %h exp=1 33334444", bus.if_rvalid_o, bus.if_rdata_o);
        end
        tick();
    endtask

    task automatic test_starvation();
        for (int unsigned k = 0; k <= STARVE_MAX + 1; k++) begin
            idle_inputs();
            bus.if_req_i = 1'b1; bus.if_addr_i = 32'h300;
            bus.dm_req_i = 1'b1; bus.dm_be_i = 4'hF; bus.dm_addr_i = 32'h400;
            bus.mem_rvalid_i = (k > 0); bus.mem_rdata_i = 32'h1000 + k;
            settle();
            checks++;
            if ({bus.if_gnt_o, bus.dm_gnt_o} !== ((k == STARVE_MAX) ? 2'b10 : 2'b01)) begin
                failures++;
                $display("FAIL starve_gnt k=%0d got=%b exp=%b", k, {bus.if_gnt_o, bus.dm_gnt_o},
                         (k == STARVE_MAX) ? 2'b10 : 2'b01);
            end
            if (k > 0) begin
                checks++;
                if ({bus.if_rvalid_o, bus.dm_rvalid_o} !== ((k - 1 == STARVE_MAX) ? 2'b10 : 2'b01)) begin
                    failures++;
                    $display("FAIL starve_rsp k=%0d got=%b exp=%b", k, {bus.if_rvalid_o, bus.dm_rvalid_o},
                             (k - 1 == STARVE_MAX) ? 2'b10 : 2'b01);
                end
            end
            tick();
        end
        idle_inputs();
        bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h5555;
        settle();
        checks++;
        if ({bus.dm_rvalid_o, bus.mem_req_o} !== 2'b10) begin
            failures++;
            $display("FAIL starve_drain got=%b exp=10", {bus.dm_rvalid_o, bus.mem_req_o});
        end
        tick();
    endtask

    task automatic test_store();
        idle_inputs();
        bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b1; bus.dm_be_i = 4'b0011;
        bus.dm_addr_i = 32'h200; bus.dm_wdata_i = 32'hDEAD_BEEF;
        settle();
        checks++;
        if ({bus.dm_gnt_o, bus.mem_req_o, bus.mem_we_o, bus.mem_be_o} !== 7'b111_0011) begin
            failures++;
            $display("FAIL store_ctrl got=%b exp=1110011", {bus.dm_gnt_o, bus.mem_req_o, bus.mem_we_o, bus.mem_be_o});
        end
        checks++;
        if (bus.mem_addr_o !== 32'h200 || bus.mem_wdata_o !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL store_data got=%h %h exp=00000200 deadbeef", bus.mem_addr_o, bus.mem_wdata_o);
        end
        tick();
        idle_inputs();
        bus.mem_rvalid_i = 1'b1;
        settle();
        checks++;
        if ({bus.dm_rvalid_o, bus.if_rvalid_o, bus.err_o} !== 3'b100) begin
            failures++;
            $display("FAIL store_ack got=%b exp=100", {bus.dm_rvalid_o, bus.if_rvalid_o, bus.err_o});
        end
        tick();
    endtask

    task automatic test_latency3();
        // DM granted first, then IF; each waits 3 cycles for its response
        for (int unsigned c = 0; c < 7; c++) begin
            idle_inputs();
            bus.if_req_i = (c < 4); bus.if_addr_i = 32'h500;
            bus.dm_req_i = (c == 0); bus.dm_be_i = 4'hF; bus.dm_addr_i = 32'h600;
            bus.mem_rvalid_i = (c == 3 || c == 6); bus.mem_rdata_i = 32'hCAFE_0000 + c;
            settle();
            checks++;
            if ({bus.mem_req_o, bus.if_gnt_o, bus.dm_gnt_o} !==
                ((c == 0) ? 3'b101 : (c == 3) ? 3'b110 : 3'b000)) begin
                failures++;
                $display("FAIL lat3_gnt c=%0d got=%b", c, {bus.mem_req_o, bus.if_gnt_o, bus.dm_gnt_o});
            end
            checks++;
            if ({bus.dm_rvalid_o, bus.if_rvalid_o} !== ((c == 3) ? 2'b10 : (c == 6) ? 2'b01 : 2'b00)) begin
                failures++;
                $display("FAIL lat3_rsp c=%0d got=%b", c, {bus.dm_rvalid_o, bus.if_rvalid_o});
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h780;
        bus.dm_req_i = 1'b1; bus.dm_be_i = 4'hF; bus.dm_addr_i = 32'h700;
        settle();
        checks++;
        if (bus.dm_gnt_o !== 1'b1) begin
            failures++;
            $display("FAIL rmid_gnt got=%b exp=1", bus.dm_gnt_o);
        end
        tick();
        idle_inputs();
        rstn = 1'b0;
        settle();
        checks++;
        if ({bus.if_gnt_o, bus.dm_gnt_o, bus.dm_rvalid_o, bus.err_o} !== 4'b0) begin
            failures++;
            $display("FAIL rmid_inreset got=%b exp=0000", {bus.if_gnt_o, bus.dm_gnt_o, bus.dm_rvalid_o, bus.err_o});
        end
        tick();
        idle_inputs();
        bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hBAD0_BAD0;
        settle();
        checks++;
        if ({bus.err_o, bus.dm_rvalid_o, bus.if_rvalid_o} !== 3'b100 || bus.dm_rdata_o !== 32'h0) begin
            failures++;
            $display("FAIL rmid_err got=%b %h exp=100 00000000", {bus.err_o, bus.dm_rvalid_o, bus.if_rvalid_o}, bus.dm_rdata_o);
        end
        tick();
        idle_inputs();
        settle();
        checks++;
        if (bus.err_o !== 1'b0) begin
            failures++;
            $display("FAIL rmid_err_pulse got=%b exp=0", bus.err_o);
        end
        // counter must restart from zero: IF wins on exactly the (STARVE_MAX+1)-th grant
        for (int unsigned k = 0; k <= STARVE_MAX; k++) begin
            idle_inputs();
            bus.if_req_i = 1'b1; bus.if_addr_i = 32'h880;
            bus.dm_req_i = 1'b1; bus.dm_be_i = 4'hF; bus.dm_addr_i = 32'h800;
            bus.mem_rvalid_i = (k > 0);
            settle();
            checks++;
            if (bus.if_gnt_o !== (k == STARVE_MAX)) begin
                failures++;
                $display("FAIL rmid_starve k=%0d got=%b exp=%b", k, bus.if_gnt_o, (k == STARVE_MAX));
            end
            tick();
        end
        idle_inputs();
        bus.mem_rvalid_i = 1'b1;
        settle();
        tick();
    endtask

    task automatic test_random();
        bit          if_pend = 0, dm_pend = 0;
        logic [31:0] if_a = '0, dm_a = '0, dm_wd = '0;
        logic        dm_we = 1'b0;
        logic [3:0]  dm_be = '0;
        int unsigned mem_cnt = 0;
        logic        gi, gd;
        for (int c = 0; c < 500; c++) begin
            if (!if_pend && c < 480 && $urandom_range(0, 1) == 0) begin
                if_pend = 1; if_a = $urandom & 32'hFFFF_FFFC;
            end
            if (!dm_pend && c < 480 && $urandom_range(0, 1) == 0) begin
                dm_pend = 1; dm_a = $urandom; dm_wd = $urandom;
                dm_we = 1'($urandom_range(0, 1)); dm_be = 4'($urandom_range(1, 15));
            end
            idle_inputs();
            bus.if_req_i = if_pend; bus.if_addr_i = if_a;
            bus.dm_req_i = dm_pend; bus.dm_we_i = dm_we; bus.dm_be_i = dm_be;
            bus.dm_addr_i = dm_a; bus.dm_wdata_i = dm_wd;
            bus.mem_rvalid_i = (mem_cnt == 1) || (mem_cnt == 0 && !m_busy && $urandom_range(0, 19) == 0);
            bus.mem_rdata_i = $urandom;
            settle();
            checks++;
            if ({bus.if_gnt_o, bus.dm_gnt_o} !== {e_if_gnt, e_dm_gnt}) begin
                failures++;
                $display("FAIL rand_gnt c=%0d got=%b exp=%b", c, {bus.if_gnt_o, bus.dm_gnt_o}, {e_if_gnt, e_dm_gnt});
            end
            checks++;
            if ({bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o} !==
                {e_mem_req, e_mem_we, e_mem_be, e_mem_addr, e_mem_wdata}) begin
                failures++;
                $display("FAIL rand_mem c=%0d got=%h exp=%h", c,
                         {bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o},
                         {e_mem_req, e_mem_we, e_mem_be, e_mem_addr, e_mem_wdata});
            end
            checks++;
            if ({bus.if_rvalid_o, bus.if_rdata_o, bus.dm_rvalid_o, bus.dm_rdata_o, bus.err_o} !==
                {e_if_rv, e_if_rd, e_dm_rv, e_dm_rd, e_err}) begin
                failures++;
                $display("FAIL rand_rsp c=%0d got=%h exp=%h", c,
                         {bus.if_rvalid_o, bus.if_rdata_o, bus.dm_rvalid_o, bus.dm_rdata_o, bus.err_o},
                         {e_if_rv, e_if_rd, e_dm_rv, e_dm_rd, e_err});
            end
            gi = e_if_gnt;
            gd = e_dm_gnt;
            tick();
            if (mem_cnt > 0) mem_cnt--;
            if (gi || gd) mem_cnt = $urandom_range(1, 3);
            if (gi) if_pend = 0;
            if (gd) dm_pend = 0;
        end
    endtask

    initial begin
        m_busy = 0; m_dm_own = 0; m_starve = 0;
        idle_inputs();
        rstn = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_starvation();
        test_store();
        test_latency3();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
